cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Two-requester round-robin arbiter placed in front of the cache controller `main`. It lets two CPU-side masters share the single `run`/`RW`/`address`/`Data_In`/`Data_Out` port of the controller. Each accepted request is latched and held on the controller port until the controller signals completion. Read data and completion are routed back to the winning requester, and a watchdog aborts accesses the controller never finishes.

## Interface
- `ADDR_W`, 48, address width (matches controller `address`)
- `DATA_W`, 16, data word width (matches controller `Data_In`/`Data_Out`)
- `TIMEOUT`, 255, maximum cycles in WAIT before abort (1..255)

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu0_run`, `cpu1_run`  in  1  request level, held until done/err
- `cpu0_RW`, `cpu1_RW`  in  1  0 = read, 1 = write
- `cpu0_address`, `cpu1_address`  in  ADDR_W  access address
- `cpu0_Data_In`, `cpu1_Data_In`  in  DATA_W  write data
- `cpu0_Data_Out`, `cpu1_Data_Out`  out  DATA_W  read data, valid with done
- `cpu0_done`, `cpu1_done`  out  1  one-cycle completion pulse
- `cpu0_err`, `cpu1_err`  out  1  one-cycle timeout pulse
- `run`  out  1  request to controller
- `RW`  out  1  latched RW of granted requester
- `address`  out  ADDR_W  latched address
- `Data_In`  out  DATA_W  latched write data
- `Data_Out`  in  DATA_W  controller read data, valid when `ctrl_done`=1
- `ctrl_done`  in  1  controller completion, sampled only in WAIT

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:**
  - A requester is eligible when its `run`=1 and its `armed` bit is 1.
  - If any requester is eligible, pick a winner, latch its `RW`/`address`/`Data_In`, set `run`=1, clear the WAIT counter, and go to WAIT.
- **Winner selection:**
  - Only one eligible → it wins.
  - Both eligible → the one that is not `last_grant` wins.
- **WAIT:**
  - `run` held at 1 and latched fields held constant.
  - Counter increments each cycle.
  - `ctrl_done`=1 → capture `Data_Out` if RW=0, set `run`=0, go to RESP.
  - Counter reaches `TIMEOUT` with no `ctrl_done` → set `run`=0, pulse `cpuN_err` for one cycle, clear `armed[N]`, set `last_grant`=N, go to IDLE.
  - `ctrl_done` and timeout in the same cycle → `ctrl_done` wins.
- **RESP:**
  - `cpuN_done`=1 for exactly one cycle.
  - On reads, `cpuN_Data_Out` shows the captured word. On writes, `cpuN_Data_Out` keeps its previous value.
  - Set `last_grant`=N, clear `armed[N]`, go to IDLE.
- **Re-arm:** `armed[N]` is set again whenever `cpuN_run`=0 is sampled. A requester must therefore drop `run` for at least one cycle between accesses; a held `run` is never served twice.
- **Input changes while waiting:** changes on a non-granted requester's inputs during WAIT/RESP are ignored until IDLE.
- `ctrl_done` outside WAIT is ignored.

## Timing
- **Reset values:**
  - Outputs: `run`=0, `RW`=0, `address`=0, `Data_In`=0, all `cpuN_done`/`cpuN_err`=0, `cpuN_Data_Out`=0.
  - Internal: state=IDLE, `last_grant`=1 (cpu0 wins the first tie), `armed`=2'b11, counter=0.
- All outputs are registered.
- **Request latency:** request sampled at edge E0 in IDLE → `run`=1 from E0.
- **Completion latency:** `ctrl_done` sampled at edge En → `run`=0 and `cpuN_done`=1 from En. Next edge → IDLE, `done`=0.
- **Throughput:** minimum 3 cycles request-to-IDLE (IDLE→WAIT→RESP→IDLE). One cycle of idle gap between back-to-back grants.
- **Timeout:** err pulse begins `TIMEOUT` cycles after entering WAIT.
- **Reset mid-operation:** the outstanding access is abandoned with no done/err pulse, and `run` drops asynchronously.
- Counter is 8-bit, saturates at `TIMEOUT`, and never wraps.

## Structure
- Package `cache_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t`
  - constants `CPU_ADDR_W`=48, `CPU_DATA_W`=16, `ARB_TIMEOUT_DEF`=255
  - `typedef struct packed {logic RW; logic [47:0] address; logic [15:0] Data_In;} cpu_req_t` for the latched request
- One sub-module `arb_watchdog`: an 8-bit saturating counter with `clear`/`enable` inputs and an `expired` output, instantiated once.

## Test plan
- Reset asserted, then cpu0 read at address 6000, `ctrl_done` 3 cycles later with `Data_Out`=16'hBEEF → `run`=1 for 4 cycles with `address`=6000, RW=0; `cpu0_done` one cycle with `cpu0_Data_Out`=16'hBEEF; `cpu1_done` stays 0.
- cpu0 and cpu1 request in the same cycle, both held and re-requested after each `done` → grants alternate cpu0, cpu1, cpu0, cpu1.
- cpu1 write to address 42 with `Data_In`=16'h1234, `ctrl_done` after 1 cycle → `RW`=1, `Data_In`=16'h1234 on the port; `cpu1_done` pulses; `cpu1_Data_Out` is unchanged.
- cpu0 request with `ctrl_done` never asserted, `TIMEOUT`=10 → `cpu0_err` pulses 10 cycles after `run` rises; `run`=0; FSM returns to IDLE; cpu1's pending request is granted next.
- cpu0 keeps `run`=1 after `done` → no second grant until `run` goes low for one cycle, then high again.
- `reset` pulsed mid-WAIT → `run` drops immediately, no done/err pulse, and the next simultaneous request goes to cpu0.

Source files
------------

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and defaults for the two-master cache port arbiter.
package cache_arb_pkg;

    localparam int CPU_ADDR_W      = 48;
    localparam int CPU_DATA_W      = 16;
    localparam int ARB_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;

    typedef struct packed {
        logic                  RW;
        logic [CPU_ADDR_W-1:0] address;
        logic [CPU_DATA_W-1:0] Data_In;
    } cpu_req_t;

    // Lone eligible requester wins; on a tie the one not served last wins.
    function automatic logic pick_winner(input logic [1:0] eligible, input logic last_grant);
        return (eligible == 2'b11) ? ~last_grant : eligible[1];
    endfunction

endpackage

// File: rtl/cache_port_arbiter_watchdog.sv
// Saturating 8-bit WAIT-cycle counter; expired_o flags the cycle whose edge reaches TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (enable_i && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Looking one count ahead makes the abort land exactly TIMEOUT edges after entry.
    assign expired_o = enable_i && (cnt_q >= (LIMIT - 8'd1));

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter letting two CPU masters share one cache controller port, with timeout abort.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu0_run,
    input  logic              cpu1_run,
    input  logic              cpu0_RW,
    input  logic              cpu1_RW,
    input  logic [ADDR_W-1:0] cpu0_address,
    input  logic [ADDR_W-1:0] cpu1_address,
    input  logic [DATA_W-1:0] cpu0_Data_In,
    input  logic [DATA_W-1:0] cpu1_Data_In,
    output logic [DATA_W-1:0] cpu0_Data_Out,
    output logic [DATA_W-1:0] cpu1_Data_Out,
    output logic              cpu0_done,
    output logic              cpu1_done,
    output logic              cpu0_err,
    output logic              cpu1_err,
    output logic              run,
    output logic              RW,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] Data_In,
    input  logic [DATA_W-1:0] Data_Out,
    input  logic              ctrl_done
);

    arb_state_t        state_q;
    cpu_req_t          req_q;
    logic              run_q;
    logic              gnt_q;
    logic              last_q;
    logic [1:0]        armed_q;
    logic [1:0]        armed_d;
    logic [1:0]        done_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] cpu0_dout_q;
    logic [DATA_W-1:0] cpu1_dout_q;

    logic [1:0] run_vec;
    logic [1:0] eligible;
    logic       winner;
    logic       grant;
    logic       expired;
    logic       abort;
    cpu_req_t   req0;
    cpu_req_t   req1;

    assign run_vec  = {cpu1_run, cpu0_run};
    assign eligible = run_vec & armed_q;
    assign winner   = pick_winner(eligible, last_q);
    assign grant    = (state_q == IDLE) && (eligible != 2'b00);
    assign abort    = (state_q == WAIT) && !ctrl_done && expired;

    assign req0 = '{RW: cpu0_RW, address: CPU_ADDR_W'(cpu0_address), Data_In: CPU_DATA_W'(cpu0_Data_In)};
    assign req1 = '{RW: cpu1_RW, address: CPU_ADDR_W'(cpu1_address), Data_In: CPU_DATA_W'(cpu1_Data_In)};

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (grant),
        .enable_i (state_q == WAIT),
        .expired_o(expired)
    );

    // A served requester is disarmed, but a low run seen on the same edge re-arms it.
    always_comb begin
        armed_d = armed_q;
        if ((state_q == RESP) || abort) begin
            armed_d[gnt_q] = 1'b0;
        end
        armed_d = armed_d | ~run_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            run_q       <= 1'b0;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            armed_q     <= 2'b11;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            cpu0_dout_q <= '0;
            cpu1_dout_q <= '0;
        end else begin
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            armed_q <= armed_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        gnt_q   <= winner;
                        req_q   <= winner ? req1 : req0;
                        run_q   <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (ctrl_done) begin
                        if (!req_q.RW) begin
                            if (gnt_q) begin
                                cpu1_dout_q <= Data_Out;
                            end else begin
                                cpu0_dout_q <= Data_Out;
                            end
                        end
                        run_q         <= 1'b0;
                        done_q[gnt_q] <= 1'b1;
                        state_q       <= RESP;
                    end else if (expired) begin
                        run_q        <= 1'b0;
                        err_q[gnt_q] <= 1'b1;
                        last_q       <= gnt_q;
                        state_q      <= IDLE;
                    end
                end
                RESP: begin
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign run           = run_q;
    assign RW            = req_q.RW;
    assign address       = ADDR_W'(req_q.address);
    assign Data_In       = DATA_W'(req_q.Data_In);
    assign cpu0_done     = done_q[0];
    assign cpu1_done     = done_q[1];
    assign cpu0_err      = err_q[0];
    assign cpu1_err      = err_q[1];
    assign cpu0_Data_Out = cpu0_dout_q;
    assign cpu1_Data_Out = cpu1_dout_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench: transaction-level arbitration model, emulated controller, decoupled response monitor.
module tb_cache_port_arbiter;

    localparam int TMO = 10;

    typedef struct {
        int          cpu;
        bit          err;
        logic [15:0] dout;
    } sb_t;

    typedef struct {
        bit          rw;
        logic [47:0] addr;
        logic [15:0] wd;
        int          delay;
        bit          tmo;
        bit          abort;
        logic [15:0] rdata;
        bit          linger;
    } plan_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  run_drv = 2'b00;
    logic        rw_drv [2];
    logic [47:0] addr_drv [2];
    logic [15:0] wd_drv [2];
    logic        cpu0_done, cpu1_done, cpu0_err, cpu1_err;
    logic [15:0] cpu0_Data_Out, cpu1_Data_Out;
    logic        run, RW;
    logic [47:0] address;
    logic [15:0] Data_In;
    logic [15:0] Data_Out;
    logic        ctrl_done;

    wire [1:0] done_w = {cpu1_done, cpu0_done};
    wire [1:0] err_w  = {cpu1_err, cpu0_err};

    sb_t   sb_q[$];
    plan_t plan_q[$];
    int    checks = 0;
    int    errors = 0;

    bit          rw_s [2];
    logic [47:0] addr_s [2];
    logic [15:0] wd_s [2];
    logic [15:0] rd_s [2];
    int          dly_s [2];
    bit          to_s [2];
    bit          lg_s [2];
    int          model_last = 1;
    logic [15:0] dout_m [2] = '{16'h0, 16'h0};

    always #5 clk = ~clk;

    cache_port_arbiter #(.ADDR_W(48), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cpu0_run(run_drv[0]), .cpu1_run(run_drv[1]),
        .cpu0_RW(rw_drv[0]), .cpu1_RW(rw_drv[1]),
        .cpu0_address(addr_drv[0]), .cpu1_address(addr_drv[1]),
        .cpu0_Data_In(wd_drv[0]), .cpu1_Data_In(wd_drv[1]),
        .cpu0_Data_Out(cpu0_Data_Out), .cpu1_Data_Out(cpu1_Data_Out),
        .cpu0_done(cpu0_done), .cpu1_done(cpu1_done),
        .cpu0_err(cpu0_err), .cpu1_err(cpu1_err),
        .run(run), .RW(RW), .address(address), .Data_In(Data_In),
        .Data_Out(Data_Out), .ctrl_done(ctrl_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none (t=%0t)", name, $time);
    endtask

    task automatic set_req(input int k, input bit rw, input logic [47:0] a, input logic [15:0] wd,
                           input int dly, input bit to, input logic [15:0] rd, input bit lg);
        rw_s[k] = rw; addr_s[k] = a; wd_s[k] = wd;
        dly_s[k] = dly; to_s[k] = to; rd_s[k] = rd; lg_s[k] = lg;
    endtask

    // Model: predict service order, then expected port fields and per-cpu responses.
    task automatic run_round(input bit [1:0] mask, input int hold0);
        int order[$];
        int first;
        int k;
        bit ok;
        if (mask == 2'b11) begin
            first = (model_last == 1) ? 0 : 1;
            order = '{first, 1 - first};
        end else begin
            order = '{mask[1] ? 1 : 0};
        end
        foreach (order[i]) begin
            k = order[i];
            plan_q.push_back('{rw: rw_s[k], addr: addr_s[k], wd: wd_s[k], delay: dly_s[k],
                               tmo: to_s[k], abort: 1'b0, rdata: rd_s[k], linger: lg_s[k]});
            if (!to_s[k] && !rw_s[k]) dout_m[k] = rd_s[k];
            sb_q.push_back('{cpu: k, err: to_s[k], dout: dout_m[k]});
            model_last = k;
        end
        $display("round mask=%b order=%p", mask, order);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            if (mask[c]) begin
                rw_drv[c] = rw_s[c]; addr_drv[c] = addr_s[c]; wd_drv[c] = wd_s[c];
                run_drv[c] = 1'b1;
            end
        end
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (run_drv[j] && (done_w[j] || err_w[j])) begin
                    if (j == 0 && hold0 > 0) begin
                        for (int h = 0; h < hold0; h++) begin
                            @(negedge clk);
                            chk("no_regrant_while_held", run, 1'b0);
                        end
                    end
                    run_drv[j] = 1'b0;
                end
            end
            if (run_drv == 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("round_timeout");
    endtask

    // Emulated cache controller: checks the latched port and answers per plan.
    initial begin : ctrl_model
        plan_t p;
        int n;
        ctrl_done = 1'b0;
        Data_Out  = 16'h0;
        forever begin
            @(negedge clk);
            Data_Out = 16'($urandom);
            if (run === 1'b1) begin
                if (plan_q.size() == 0) begin
                    fail("unplanned_grant");
                    n = 0;
                    while (run === 1'b1 && n < 500) begin @(negedge clk); n++; end
                end else begin
                    p = plan_q.pop_front();
                    chk("port_RW", RW, p.rw);
                    chk("port_address", address, p.addr);
                    chk("port_Data_In", Data_In, p.wd);
                    if (p.abort) begin
                        n = 0;
                        while (run === 1'b1 && n < 500) begin @(negedge clk); n++; end
                    end else if (p.tmo) begin
                        n = 1;
                        while (n < 400) begin
                            @(negedge clk);
                            if (run !== 1'b1) break;
                            n++;
                        end
                        chk("timeout_run_cycles", n, TMO);
                    end else begin
                        for (int k = 1; k < p.delay; k++) @(negedge clk);
                        chk("run_held", run, 1'b1);
                        chk("address_held", address, p.addr);
                        ctrl_done = 1'b1;
                        Data_Out  = p.rdata;
                        @(negedge clk);
                        chk("run_drop_on_done", run, 1'b0);
                        if (p.linger) @(negedge clk);
                        ctrl_done = 1'b0;
                    end
                end
            end
        end
    end

    // Response monitor: every done/err pulse consumes one scoreboard entry.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (done_w[k] === 1'b1 || err_w[k] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        fail($sformatf("unexpected_pulse_cpu%0d", k));
                    end else begin
                        e = sb_q.pop_front();
                        $display("resp cpu%0d done=%b err=%b dout=%h (exp cpu%0d err=%b dout=%h)",
                                 k, done_w[k], err_w[k], k ? cpu1_Data_Out : cpu0_Data_Out, e.cpu, e.err, e.dout);
                        chk("resp_cpu", k, e.cpu);
                        chk("resp_is_err", err_w[k], e.err);
                        chk("resp_both_pulses", done_w[k] & err_w[k], 1'b0);
                        if (!e.err) chk("resp_Data_Out", k ? cpu1_Data_Out : cpu0_Data_Out, e.dout);
                    end
                end
            end
        end
    end

    initial begin : guard
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        for (int k = 0; k < 2; k++) begin rw_drv[k] = 1'b0; addr_drv[k] = '0; wd_drv[k] = '0; end
        repeat (2) @(negedge clk);
        chk("rst_run", run, 1'b0);
        chk("rst_RW", RW, 1'b0);
        chk("rst_address", address, 48'h0);
        chk("rst_Data_In", Data_In, 16'h0);
        chk("rst_done_err", {done_w, err_w}, 4'h0);
        chk("rst_dout0", cpu0_Data_Out, 16'h0);
        chk("rst_dout1", cpu1_Data_Out, 16'h0);
        reset = 1'b0;

        set_req(0, 1'b0, 48'd6000, 16'h0, 4, 1'b0, 16'hBEEF, 1'b0);
        run_round(2'b01, 0);
        set_req(1, 1'b0, 48'd7, 16'h0, 2, 1'b0, 16'h5A5A, 1'b1);
        run_round(2'b10, 0);
        set_req(1, 1'b1, 48'd42, 16'h1234, 1, 1'b0, 16'hDEAD, 1'b0);
        run_round(2'b10, 0);
        for (int r = 0; r < 2; r++) begin
            set_req(0, 1'b0, 48'h100 + 48'(r), 16'h0, 2, 1'b0, 16'hA000 + 16'(r), 1'b0);
            set_req(1, 1'b0, 48'h200 + 48'(r), 16'h0, 3, 1'b0, 16'hB000 + 16'(r), 1'b0);
            run_round(2'b11, 0);
        end
        set_req(0, 1'b0, 48'h300, 16'h0, 1, 1'b1, 16'h0, 1'b0);
        set_req(1, 1'b1, 48'h301, 16'h7777, 2, 1'b0, 16'h0, 1'b0);
        run_round(2'b11, 0);
        set_req(0, 1'b0, 48'h400, 16'h0, 2, 1'b0, 16'hC0DE, 1'b0);
        run_round(2'b01, 5);

        plan_q.push_back('{rw: 1'b0, addr: 48'h500, wd: 16'h0, delay: 0, tmo: 1'b0,
                           abort: 1'b1, rdata: 16'h0, linger: 1'b0});
        @(negedge clk);
        rw_drv[0] = 1'b0; addr_drv[0] = 48'h500; run_drv[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("run_in_wait", run, 1'b1);
        reset = 1'b1;
        #1;
        chk("run_async_drop", run, 1'b0);
        chk("no_pulse_on_reset", {done_w, err_w}, 4'h0);
        @(negedge clk);
        run_drv = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        model_last = 1;
        dout_m = '{16'h0, 16'h0};
        chk("reset_clears_dout0", cpu0_Data_Out, 16'h0);
        set_req(0, 1'b0, 48'h600, 16'h0, 2, 1'b0, 16'h1111, 1'b0);
        set_req(1, 1'b0, 48'h601, 16'h0, 2, 1'b0, 16'h2222, 1'b0);
        run_round(2'b11, 0);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 2; k++) begin
                set_req(k, 1'($urandom_range(0, 1)), {16'($urandom), 32'($urandom)}, 16'($urandom),
                        $urandom_range(1, 6), ($urandom_range(0, 7) == 0), 16'($urandom),
                        1'($urandom_range(0, 1)));
            end
            run_round(2'($urandom_range(1, 3)), 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        chk("plan_drained", 64'(plan_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
